// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel coordinates, display enable, syncs,
// line/frame markers and a free-running completed-frame counter.
// Counters and outputs advance only on cycles where i_pix_en is high.
module video_timing_gen #(
    parameter int unsigned H_RES  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter bit          H_POL  = 1'b0,
    parameter bit          V_POL  = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_en,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_de,
    output logic        o_h_sync,
    output logic        o_v_sync,
    output logic        o_line_start,
    output logic        o_frame_start,
    output logic [15:0] o_frame_cnt
);

    localparam int unsigned CW       = 16;
    localparam int unsigned H_TOTAL  = H_RES + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_RES + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_RES + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_RES + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Totals must fit the 16-bit position counters.
    if (H_TOTAL > 65536 || V_TOTAL > 65536) begin : g_cfg_check
        $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 65536");
    end

    logic [CW-1:0] cx_q, cx_d;
    logic [CW-1:0] cy_q, cy_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          de_q, de_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;
    logic [CW-1:0] fcnt_q, fcnt_d;

    logic h_last_c;
    logic v_last_c;
    logic de_c;
    logic hs_act_c;
    logic vs_act_c;

    // Decode of the slot currently held in the position counters.
    always_comb begin
        h_last_c = (cx_q == CW'(H_TOTAL - 1));
        v_last_c = (cy_q == CW'(V_TOTAL - 1));
        de_c     = (32'(cx_q) < H_RES) && (32'(cy_q) < V_RES);
        hs_act_c = (32'(cx_q) >= HS_START) && (32'(cx_q) < HS_END);
        vs_act_c = (32'(cy_q) >= VS_START) && (32'(cy_q) < VS_END);
    end

    // Next state: present the current slot and step the raster on enabled cycles.
    always_comb begin
        cx_d   = cx_q;
        cy_d   = cy_q;
        x_d    = x_q;
        y_d    = y_q;
        de_d   = de_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        ls_d   = 1'b0;
        fs_d   = 1'b0;
        fcnt_d = fcnt_q;
        if (i_pix_en) begin
            x_d  = cx_q;
            y_d  = cy_q;
            de_d = de_c;
            hs_d = hs_act_c ? H_POL : ~H_POL;
            vs_d = vs_act_c ? V_POL : ~V_POL;
            ls_d = (cx_q == '0);
            fs_d = (cx_q == '0) && (cy_q == '0);
            if (h_last_c) begin
                cx_d = '0;
                if (v_last_c) begin
                    cy_d   = '0;
                    fcnt_d = fcnt_q + CW'(1);
                end else begin
                    cy_d = cy_q + CW'(1);
                end
            end else begin
                cx_d = cx_q + CW'(1);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cx_q   <= '0;
            cy_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            de_q   <= 1'b0;
            hs_q   <= ~H_POL;
            vs_q   <= ~V_POL;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            fcnt_q <= '0;
        end else begin
            cx_q   <= cx_d;
            cy_q   <= cy_d;
            x_q    <= x_d;
            y_q    <= y_d;
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_de          = de_q;
    assign o_h_sync      = hs_q;
    assign o_v_sync      = vs_q;
    assign o_line_start  = ls_q;
    assign o_frame_start = fs_q;
    assign o_frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default 640x480 instance and a tiny 7x6 instance,
// each compared every cycle against an arithmetic model of the raster.
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, en_a = 1'b0;
    logic rst_b = 1'b1, en_b = 1'b0;

    logic [15:0] x_a, y_a, fc_a, x_b, y_b, fc_b;
    logic de_a, hs_a, vs_a, ls_a, fs_a;
    logic de_b, hs_b, vs_b, ls_b, fs_b;

    int n_total = 0;
    int n_pass  = 0;

    video_timing_gen dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_pix_en(en_a),
        .o_x(x_a), .o_y(y_a), .o_de(de_a), .o_h_sync(hs_a), .o_v_sync(vs_a),
        .o_line_start(ls_a), .o_frame_start(fs_a), .o_frame_cnt(fc_a)
    );

    video_timing_gen #(
        .H_RES(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b0)
    ) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_pix_en(en_b),
        .o_x(x_b), .o_y(y_b), .o_de(de_b), .o_h_sync(hs_b), .o_v_sync(vs_b),
        .o_line_start(ls_b), .o_frame_start(fs_b), .o_frame_cnt(fc_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Expected outputs after n enabled edges since reset: slot n-1 of the raster,
    // frames completed = floor(n / frame_size), pulses only right after an enabled edge.
    function automatic logic [63:0] expv(input longint n, input bit le, input logic [15:0] off,
                                         input int hres, input int hfp, input int hsy, input int hbp,
                                         input int vres, input int vfp, input int vsy, input int vbp,
                                         input bit hpol, input bit vpol);
        longint ht = hres + hfp + hsy + hbp;
        longint vt = vres + vfp + vsy + vbp;
        longint s, x = 0, y = 0;
        bit de = 1'b0, hs = ~hpol, vs = ~vpol, ls = 1'b0, fs = 1'b0;
        logic [15:0] fc;
        fc = 16'(n / (ht * vt)) + off;
        if (n > 0) begin
            s  = n - 1;
            x  = s % ht;
            y  = (s / ht) % vt;
            de = (x < hres) && (y < vres);
            hs = (x >= hres + hfp && x < hres + hfp + hsy) ? hpol : ~hpol;
            vs = (y >= vres + vfp && y < vres + vfp + vsy) ? vpol : ~vpol;
            ls = le && (x == 0);
            fs = ls && (y == 0);
        end
        return {11'b0, 16'(x), 16'(y), de, hs, vs, ls, fs, fc};
    endfunction

    // Model state: enabled edges since reset and whether the last edge was enabled.
    longint na = 0, nb = 0;
    bit le_a = 1'b0, le_b = 1'b0, valid_a = 1'b0, valid_b = 1'b0;
    logic [15:0] off_b = 16'd0;

    always @(posedge clk) begin
        if (rst_a) begin
            na <= 0; le_a <= 1'b0; valid_a <= 1'b1;
        end else if (en_a) begin
            na <= na + 1; le_a <= 1'b1;
        end else begin
            le_a <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst_b) begin
            nb <= 0; le_b <= 1'b0; valid_b <= 1'b1;
        end else if (en_b) begin
            nb <= nb + 1; le_b <= 1'b1;
        end else begin
            le_b <= 1'b0;
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (valid_a)
            chk("cycle_a", {11'b0, x_a, y_a, de_a, hs_a, vs_a, ls_a, fs_a, fc_a},
                expv(na, le_a, 16'd0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
        if (valid_b)
            chk("cycle_b", {11'b0, x_b, y_b, de_b, hs_b, vs_b, ls_b, fs_b, fc_b},
                expv(nb, le_b, off_b, 4, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stim_a();
        int de_cnt, hs_cnt, hs_first, hs_last;
        rst_a = 1'b1; en_a = 1'b1;
        repeat (3) tick();
        chk("a_rst_x", 64'(x_a), 64'd0);
        chk("a_rst_y", 64'(y_a), 64'd0);
        chk("a_rst_de", 64'(de_a), 64'd0);
        chk("a_rst_syncs", 64'({hs_a, vs_a}), 64'd3);
        chk("a_rst_pulses", 64'({ls_a, fs_a}), 64'd0);
        chk("a_rst_fcnt", 64'(fc_a), 64'd0);
        rst_a = 1'b0;
        tick();
        chk("a_first_slot", 64'({x_a, y_a, de_a, ls_a, fs_a}), 64'({16'd0, 16'd0, 3'b111}));
        de_cnt = 1; hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int i = 1; i < 800; i++) begin
            tick();
            if (de_a) de_cnt++;
            if (!hs_a) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(x_a);
                hs_last = int'(x_a);
            end
        end
        chk("a_line_de_count", 64'(de_cnt), 64'd640);
        chk("a_hsync_count", 64'(hs_cnt), 64'd96);
        chk("a_hsync_first", 64'(hs_first), 64'd656);
        chk("a_hsync_last", 64'(hs_last), 64'd751);
        chk("a_line_end_x", 64'(x_a), 64'd799);
        tick();
        chk("a_wrap", 64'({x_a, y_a, ls_a, fs_a}), 64'({16'd0, 16'd1, 2'b10}));
        repeat (1700) tick();
        for (int i = 0; i < 3200; i++) begin
            en_a = (i % 4 == 0);
            tick();
        end
        repeat (5000) begin
            en_a = ($urandom_range(0, 3) != 0);
            tick();
        end
        en_a = 1'b0;
        tick();
    endtask

    task automatic stim_b();
        int fs_cnt, hs_cnt, hs_bad;
        rst_b = 1'b1; en_b = 1'b1;
        repeat (3) tick();
        rst_b = 1'b0;
        repeat (20) tick();
        chk("b_at_5_2", 64'({x_b, y_b, hs_b, vs_b}), 64'({16'd5, 16'd2, 2'b11}));
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("b_midrst_xy", 64'({x_b, y_b}), 64'd0);
        chk("b_midrst_flags", 64'({de_b, hs_b, vs_b, ls_b, fs_b}), 64'(5'b00100));
        chk("b_midrst_fcnt", 64'(fc_b), 64'd0);
        fs_cnt = 0; hs_cnt = 0; hs_bad = 0;
        repeat (126) begin
            tick();
            if (fs_b) fs_cnt++;
            if (hs_b) begin
                hs_cnt++;
                if (x_b != 16'd5) hs_bad++;
            end
        end
        chk("b_frame_starts", 64'(fs_cnt), 64'd3);
        chk("b_hsync_count", 64'(hs_cnt), 64'd18);
        chk("b_hsync_pos", 64'(hs_bad), 64'd0);
        chk("b_fcnt_3", 64'(fc_b), 64'd3);
        repeat (2500) begin
            rst_b = ($urandom_range(0, 299) == 0);
            en_b  = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst_b = 1'b0; en_b = 1'b0;
        tick();
        force dut_b.fcnt_q = 16'hFFFF;
        off_b = 16'hFFFF - 16'(nb / 42);
        tick();
        release dut_b.fcnt_q;
        tick();
        chk("b_fcnt_forced", 64'(fc_b), 64'hFFFF);
        en_b = 1'b1;
        repeat (42) tick();
        chk("b_fcnt_wrap", 64'(fc_b), 64'd0);
        repeat (100) begin
            en_b = ($urandom_range(0, 1) != 0);
            tick();
        end
        en_b = 1'b0;
        tick();
    endtask

    initial begin
        fork
            stim_a();
            stim_b();
        join
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: run exceeded its time limit");
        $fatal(1);
    end

endmodule
